param_updown_counter: RTL and testbench

Next-generation parametrised counter replacing the fixed 4-bit up counter. Provides:
- up/down counting with a runtime-programmable terminal value (modulus) and synchronous parallel load;
- a registered terminal-count pulse;
- a one-shot mode that halts at terminal instead of wrapping.

Used as a general timebase and event counter across the design.

---
 rtl/param_updown_counter_pkg.sv | 7 +
 rtl/param_updown_counter_sat_event_counter.sv | 12 +
 rtl/param_updown_counter.sv | 56 +++++
 tb/tb_param_updown_counter.sv | 116 +++++++++++
 4 files changed

// File: rtl/param_updown_counter_pkg.sv
// param_updown_counter_pkg: shared types and constants for the up/down counter.
package param_updown_counter_pkg;
  typedef enum logic {COUNT, HALT} cnt_state_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;
  localparam int WRAP_CNT_W = 8;
endpackage

// File: rtl/param_updown_counter_sat_event_counter.sv
// sat_event_counter: saturating event counter with synchronous clear.
module sat_event_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= clr ? '0 : (inc && cnt != '1) ? cnt + WIDTH'(1) : cnt;
endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: up/down modulus counter with load, terminal pulse and one-shot halt.
// Optional wrap_cnt output enabled by PARAM_UPDOWN_COUNTER_WRAP_CNT_EN.
module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_max,
  input  logic             one_shot,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done
`ifdef PARAM_UPDOWN_COUNTER_WRAP_CNT_EN
  ,
  output logic [WRAP_CNT_W-1:0] wrap_cnt
`endif
);
  cnt_state_t state, state_nxt;
  logic cnt_act, up_term, dn_term, term, tc_nxt;
  logic [WIDTH-1:0] q_ld, q_cnt, q_nxt;
  always_ff @(posedge clk) begin
    state <= rst ? COUNT : state_nxt;
    done  <= rst ? 1'b0 : state_nxt == HALT;
    q     <= rst ? '0 : q_nxt;
    tc    <= rst ? 1'b0 : tc_nxt;
  end
  always_comb
    state_nxt = load ? COUNT : (term && one_shot) ? HALT : state;
  // Down count above a lowered modulus clamps to mod_max without a terminal event.
  always_comb begin
    q_ld    = load_val > mod_max ? mod_max : load_val;
    cnt_act = en && state == COUNT;
    up_term = q >= mod_max;
    dn_term = q == '0;
    term    = cnt_act && (up_dn == DIR_UP ? up_term : dn_term);
    q_cnt   = up_dn == DIR_UP ? (up_term ? (one_shot ? mod_max : '0) : q + WIDTH'(1))
            : q > mod_max ? mod_max
            : dn_term ? (one_shot ? '0 : mod_max) : q - WIDTH'(1);
    q_nxt   = load ? q_ld : cnt_act ? q_cnt : q;
    tc_nxt  = !load && term;
  end
`ifdef PARAM_UPDOWN_COUNTER_WRAP_CNT_EN
  sat_event_counter #(.WIDTH(WRAP_CNT_W)) u_wrap (
    .clk(clk),
    .clr(rst || load),
    .inc(tc_nxt),
    .cnt(wrap_cnt)
  );
`endif
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: directed scoreboard bench for param_updown_counter (WIDTH=4).
module tb_param_updown_counter;
  typedef struct {
    logic [3:0] q;
    logic       tc;
    logic       done;
    int         w;
    string      nm;
  } exp_t;
  logic clk = 1'b0;
  logic rst, en, up_dn, load, one_shot;
  logic [3:0] load_val, mod_max, q;
  logic tc, done;
`ifdef PARAM_UPDOWN_COUNTER_WRAP_CNT_EN
  logic [7:0] wrap_cnt;
`endif
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  param_updown_counter #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .mod_max(mod_max), .one_shot(one_shot),
    .q(q), .tc(tc), .done(done)
`ifdef PARAM_UPDOWN_COUNTER_WRAP_CNT_EN
    , .wrap_cnt(wrap_cnt)
`endif
  );
  task automatic step(input logic r, e, u, l, input logic [3:0] lv, mm, input logic o,
                      input logic [3:0] eq, input logic etc, ed, input int ew, input string nm);
    rst = r; en = e; up_dn = u; load = l; load_val = lv; mod_max = mm; one_shot = o;
    @(posedge clk);
    sb.push_back('{eq, etc, ed, ew, nm});
    #1;
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      checks++;
      if (q !== x.q || tc !== x.tc || done !== x.done) begin
        failures++;
        $display("FAIL %s: got q=%0d tc=%b done=%b expected q=%0d tc=%b done=%b",
                 x.nm, q, tc, done, x.q, x.tc, x.done);
      end
`ifdef PARAM_UPDOWN_COUNTER_WRAP_CNT_EN
      if (x.w >= 0) begin
        checks++;
        if (wrap_cnt !== 8'(x.w)) begin
          failures++;
          $display("FAIL %s_wrap: got wrap_cnt=%0d expected %0d", x.nm, wrap_cnt, x.w);
        end
      end
`endif
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end
  initial begin
    step(1,0,1,0,0,15,0, 0,0,0, 0,"rst_a");
    step(1,0,1,0,0,15,0, 0,0,0, 0,"rst_b");
    for (int i = 1; i <= 15; i++) step(0,1,1,0,0,15,0, 4'(i),0,0, -1,"up15");
    step(0,1,1,0,0,15,0, 0,1,0, 1,"wrap15");
    step(0,1,1,0,0,15,0, 1,0,0, 1,"after_wrap15");
    step(0,0,1,1,0,9,0, 0,0,0, 0,"ld0");
    for (int i = 1; i <= 9; i++) step(0,1,1,0,0,9,0, 4'(i),0,0, -1,"up9");
    step(0,1,1,0,0,9,0, 0,1,0, 1,"wrap9");
    for (int i = 1; i <= 4; i++) step(0,1,1,0,0,9,0, 4'(i),0,0, -1,"up9b");
    for (int i = 3; i >= 0; i--) step(0,1,0,0,0,9,0, 4'(i),0,0, -1,"dn9");
    step(0,1,0,0,0,9,0, 9,1,0, 2,"dnwrap9");
    step(0,1,0,0,0,9,0, 8,0,0, -1,"dn8");
    step(0,1,0,0,0,5,0, 5,0,0, 2,"dn_clamp");
    step(0,1,0,0,0,5,0, 4,0,0, -1,"dn4");
    step(0,1,1,1,12,9,0, 9,0,0, 0,"ld_clamp");
    step(0,1,1,1,3,9,0, 3,0,0, 0,"ld_wins");
    step(0,0,1,0,3,9,0, 3,0,0, 0,"hold");
    step(0,0,1,1,0,3,1, 0,0,0, 0,"ld_os");
    for (int i = 1; i <= 3; i++) step(0,1,1,0,0,3,1, 4'(i),0,0, -1,"os_up");
    step(0,1,1,0,0,3,1, 3,1,1, 1,"halt");
    step(0,1,1,0,0,3,1, 3,0,1, 1,"halt_hold_a");
    step(0,1,1,0,0,3,1, 3,0,1, 1,"halt_hold_b");
    step(0,1,1,0,0,3,0, 3,0,1, 1,"os_cleared");
    step(0,1,0,0,0,3,1, 3,0,1, 1,"halt_dn");
    step(0,0,1,1,0,3,1, 0,0,0, 0,"ld_resume");
    step(0,1,1,0,0,3,1, 1,0,0, 0,"resumed");
    step(0,0,0,1,1,3,1, 1,0,0, 0,"ld1");
    step(0,1,0,0,0,3,1, 0,0,0, 0,"os_dn0");
    step(0,1,0,0,0,3,1, 0,1,1, 1,"dn_halt");
    step(0,0,1,1,3,3,1, 3,0,0, 0,"ld3");
    step(0,1,1,0,0,1,1, 1,1,1, 1,"os_lowmod");
    step(0,0,1,1,5,9,0, 5,0,0, 0,"ld5");
    step(0,1,1,0,0,2,0, 0,1,0, 1,"fr_lowmod");
    step(0,0,1,1,7,9,0, 7,0,0, 0,"ld7");
    step(1,1,1,1,5,9,0, 0,0,0, 0,"rst_count");
    step(0,0,1,1,3,3,1, 3,0,0, 0,"ld3_os");
    step(0,1,1,0,0,3,1, 3,1,1, 1,"halt5");
    step(1,1,1,1,5,3,1, 0,0,0, 0,"rst_halt");
    step(0,1,1,0,0,3,0, 1,0,0, 0,"post_rst");
    step(0,0,1,1,0,0,0, 0,0,0, 0,"ld_m0");
    for (int i = 1; i <= 300; i++) step(0,1,1,0,0,0,0, 0,1,0, (i > 255) ? 255 : i,"m0_up");
    step(0,1,0,0,0,0,0, 0,1,0, 255,"m0_dn");
    step(0,0,0,0,0,0,0, 0,0,0, 255,"m0_idle");
    step(0,0,1,1,0,0,0, 0,0,0, 0,"ld_clr");
    step(0,1,1,0,0,0,1, 0,1,1, 1,"m0_os");
    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
